// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the 12-bit memory port among fetch (0),
// execute (1) and I/O/DMA (2). Each access runs IDLE -> SETUP -> ACCESS
// (MEM_LAT cycles) -> DONE, and every output is registered.
// Optional feature macro: ARB_RR_EN selects round-robin arbitration.
// Without it, arbitration is fixed priority 2 > 1 > 0.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] we_req,
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic       mem_en,
  output logic       mem_we,
  output logic [2:0] done,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       wr;
  logic [1:0] pick;

`ifdef ARB_RR_EN
  logic [1:0] ptr;

  // Round-robin winner: search starts at the pointer and wraps 2 -> 0
  always_comb begin
    pick = 2'd0;
    case (ptr)
      2'd1:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Pointer moves to the port after the one just served, once it completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (state == DONE) begin
      ptr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    end
  end
`else
  // Fixed-priority winner: I/O beats execute beats fetch
  always_comb begin
    pick = 2'd0;
    if (req[2]) begin
      pick = 2'd2;
    end else if (req[1]) begin
      pick = 2'd1;
    end
  end
`endif

  // Access sequencer; the winner is latched in IDLE and requests are ignored until the next IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      wr     <= 1'b0;
      gnt    <= 3'b000;
      sel    <= 2'd0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      done   <= 3'b000;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= SETUP;
            wr    <= we_req[pick];
            gnt   <= 3'b001 << pick;
            sel   <= pick;
            busy  <= 1'b1;
          end
        end
        SETUP: begin
          state  <= ACCESS;
          cnt    <= LAT_LOAD;
          mem_en <= 1'b1;
          mem_we <= wr;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state  <= DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            done   <= gnt;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          gnt   <= 3'b000;
          done  <= 3'b000;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a queue of expected accesses
// consumed by a monitor that follows every grant through to its done pulse.
// Two extra instances with MEM_LAT 1 and 15 cover the latency extremes.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req, we_req;
  logic [2:0] gnt, done;
  logic [1:0] sel;
  logic       mem_en, mem_we, busy;

  logic [2:0] req_a, req_b, gnt_a, gnt_b, done_a, done_b;
  logic [1:0] sel_a, sel_b;
  logic       en_a, en_b, we_a, we_b, busy_a, busy_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_events = 0;

  typedef struct {
    int port;
    bit we;
    int start;
  } exp_t;

  exp_t sb[$];
  int   starts[$];

  mem_port_arbiter #(.MEM_LAT(LAT)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .we_req(we_req),
    .gnt(gnt), .sel(sel), .mem_en(mem_en), .mem_we(mem_we),
    .done(done), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req_a), .we_req(3'b000),
    .gnt(gnt_a), .sel(sel_a), .mem_en(en_a), .mem_we(we_a),
    .done(done_a), .busy(busy_a)
  );

  mem_port_arbiter #(.MEM_LAT(15)) u15 (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we_req(3'b000),
    .gnt(gnt_b), .sel(sel_b), .mem_en(en_b), .mem_we(we_b),
    .done(done_b), .busy(busy_b)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter, stable when sampled on the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] w);
    req    = r;
    we_req = w;
  endtask

  function automatic int expSel(input logic [2:0] g);
    case (g)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  task automatic waitDone(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (done == 3'b000 && t < 60);
    if (done == 3'b000) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  task automatic waitMemEn(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_en && t < 30);
    if (!mem_en) checkOutput({name, "_mem_en_timeout"}, 0, 1);
  endtask

  function automatic logic [2:0] swGnt(input int w);
    return (w == 0) ? gnt_a : gnt_b;
  endfunction

  function automatic logic swEn(input int w);
    return (w == 0) ? en_a : en_b;
  endfunction

  function automatic logic [2:0] swDone(input int w);
    return (w == 0) ? done_a : done_b;
  endfunction

  function automatic int swMisc(input int w);
    return (w == 0) ? int'({sel_a, we_a, busy_a}) : int'({sel_b, we_b, busy_b});
  endfunction

  task automatic setSweepReq(input int w, input logic [2:0] v);
    if (w == 0) req_a = v;
    else        req_b = v;
  endtask

  // Holds port 0 requesting and measures strobe width and grant-to-grant period
  task automatic sweepCheck(input int w, input int lat);
    int t, en_w, period, done_cnt, misc_bad;
    t = 0; en_w = 0; period = 0; done_cnt = 0; misc_bad = 0;
    setSweepReq(w, 3'b001);
    @(negedge clk);
    while (swGnt(w) == 3'b000 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checkOutput($sformatf("sweep%0d_first_gnt", lat), int'(swGnt(w)), 1);
    while (swGnt(w) != 3'b000 && t < 100) begin
      if (swEn(w)) en_w++;
      if (swDone(w) == 3'b001) done_cnt++;
      if (swMisc(w) != 1) misc_bad++;
      period++;
      @(negedge clk);
      t++;
    end
    while (swGnt(w) == 3'b000 && t < 100) begin
      period++;
      @(negedge clk);
      t++;
    end
    setSweepReq(w, 3'b000);
    checkOutput($sformatf("sweep%0d_en_width", lat), en_w, lat);
    checkOutput($sformatf("sweep%0d_occupancy", lat), period, lat + 3);
    checkOutput($sformatf("sweep%0d_done_pulses", lat), done_cnt, 1);
    checkOutput($sformatf("sweep%0d_sel_we_busy", lat), misc_bad, 0);
  endtask

  // Monitor: tracks each grant and scores it against the expected queue on done
  initial begin : monitor
    bit         active, prev_done, bad;
    logic [2:0] cur_gnt;
    int         start, en_cnt, we_cnt;
    exp_t       e;
    active = 0; prev_done = 0; bad = 0; cur_gnt = 3'b000;
    start = 0; en_cnt = 0; we_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active    = 0;
        prev_done = 0;
      end else begin
        if (prev_done) checkOutput("bubble_gnt", int'(gnt), 0);
        prev_done = 0;
        if (gnt != 3'b000 && !active) begin
          active  = 1;
          cur_gnt = gnt;
          start   = cyc;
          en_cnt  = 0;
          we_cnt  = 0;
          bad     = 0;
          starts.push_back(cyc);
        end
        if (active) begin
          if (gnt != cur_gnt || busy != 1'b1 || int'(sel) != expSel(cur_gnt)) bad = 1;
          if (mem_en) begin
            en_cnt++;
            if (mem_we) we_cnt++;
          end
        end else begin
          checkOutput("idle_quiet", int'({busy, mem_en}), 0);
        end
        if (done != 3'b000) begin
          done_events++;
          if (sb.size() == 0) begin
            checkOutput("unexpected_done", int'(done), 0);
          end else begin
            e = sb.pop_front();
            checkOutput("done_port", int'(done), 1 << e.port);
            checkOutput("gnt_port", int'(cur_gnt), 1 << e.port);
            checkOutput("en_width", en_cnt, LAT);
            checkOutput("we_cycles", we_cnt, e.we ? LAT : 0);
            checkOutput("done_latency", cyc - start, LAT + 1);
            if (e.start >= 0) checkOutput("grant_cycle", start, e.start);
            checkOutput("hold_gnt_sel_busy", int'(bad), 0);
            checkOutput("done_mem_en", int'(mem_en), 0);
          end
          active    = 0;
          prev_done = 1;
        end
      end
    end
  end

  // Directed stimulus
  initial begin : stim
    int base;
    rst_n = 1'b0;
    req_a = 3'b000;
    req_b = 3'b000;
    applyStimulus(3'b111, 3'b000);

    repeat (3) @(negedge clk);
    checkOutput("rst_gnt", int'(gnt), 0);
    checkOutput("rst_sel", int'(sel), 0);
    checkOutput("rst_mem_en", int'(mem_en), 0);
    checkOutput("rst_mem_we", int'(mem_we), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_busy", int'(busy), 0);
`ifdef ARB_RR_EN
    sb.push_back('{0, 1'b0, cyc + 1});
`else
    sb.push_back('{2, 1'b0, cyc + 1});
`endif
    rst_n = 1'b1;
    waitDone("first_after_reset");
    applyStimulus(3'b000, 3'b000);
    repeat (2) @(negedge clk);

    sb.push_back('{0, 1'b0, cyc + 1});
    applyStimulus(3'b001, 3'b000);
    waitDone("single_read");
    applyStimulus(3'b000, 3'b000);
    repeat (2) @(negedge clk);

    sb.push_back('{2, 1'b1, cyc + 1});
    applyStimulus(3'b100, 3'b100);
    waitDone("single_write");
    applyStimulus(3'b000, 3'b000);
    repeat (2) @(negedge clk);

    sb.push_back('{1, 1'b0, cyc + 1});
    applyStimulus(3'b010, 3'b000);
    waitMemEn("drop");
    applyStimulus(3'b000, 3'b010);
    waitDone("drop");
    applyStimulus(3'b000, 3'b000);
    repeat (2) @(negedge clk);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    starts.delete();
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_RR_EN
      sb.push_back('{i % 3, (i % 3) != 1, (i == 0) ? cyc + 1 : -1});
`else
      sb.push_back('{2, 1'b1, (i == 0) ? cyc + 1 : -1});
`endif
    end
    applyStimulus(3'b111, 3'b101);
    for (int i = 0; i < 6; i++) waitDone("contention");
    applyStimulus(3'b000, 3'b000);
    repeat (3) @(negedge clk);
    checkOutput("contention_grants", starts.size(), 6);
    for (int i = 1; i < 6; i++) begin
      if (i < starts.size()) checkOutput("contention_occupancy", starts[i] - starts[i-1], LAT + 3);
    end

    base = done_events;
    applyStimulus(3'b010, 3'b010);
    waitMemEn("abort");
    #2;
    rst_n = 1'b0;
    applyStimulus(3'b000, 3'b000);
    #1;
    checkOutput("abort_mem_en", int'(mem_en), 0);
    checkOutput("abort_mem_we", int'(mem_we), 0);
    checkOutput("abort_gnt", int'(gnt), 0);
    checkOutput("abort_sel", int'(sel), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("abort_no_done", done_events, base);
    checkOutput("abort_idle", int'(busy), 0);

    sweepCheck(0, 1);
    sweepCheck(1, 15);
    repeat (25) @(negedge clk);

    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time limit so the run can never hang
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
